// File: rtl/rtc_init_sequencer.sv
// -----------------------------------------------------------------------------
// rtc_init_sequencer
//
// Power-up initialisation sequencer for an RTC on a multiplexed AD bus.
// A rising edge on `en` walks an external register table (NUM_REGS
// address/data pairs, looked up combinationally through tbl_idx) and writes
// each pair to the RTC. Each entry is an address cycle, a data cycle and a
// gap. Every bus phase (setup, strobe, hold, gap) lasts PHASE_CYC clocks.
// Dropping `en` aborts an active sequence or clears `done`.
//
// Optional feature (compile-time macro RTC_INIT_READBACK_EN):
//   When defined, each data cycle is followed by a read cycle. The sampled
//   bus_in is compared with the table data. The first mismatch sets the
//   sticky err flag and records err_idx. When undefined, rd_o stays 1,
//   err/err_idx stay 0 and bus_in is ignored.
//
// Parameters:
//   DATA_W    AD bus / table data width
//   NUM_REGS  table entries to write (1..256)
//   PHASE_CYC clocks per bus phase (>= 1)
//   IDX_W     width of tbl_idx / err_idx (>= clog2(NUM_REGS))
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   en        level enable: rising edge starts, low aborts / clears done
//   tbl_idx   current table index (to external ROM)
//   tbl_addr  RTC register address for tbl_idx (from ROM)
//   tbl_data  register value for tbl_idx (from ROM)
//   bus_in    AD bus read data (read-back only)
//   bus_out   AD bus drive value
//   bus_oe    AD bus output enable
//   ad_o      0 = address cycle, 1 = data cycle
//   cs_o      chip select, active low
//   wr_o      write strobe, active low
//   rd_o      read strobe, active low
//   busy      sequence in progress
//   done      all entries written
//   err       sticky read-back mismatch
//   err_idx   table index of the first mismatch
// -----------------------------------------------------------------------------
module rtc_init_sequencer #(
  parameter int DATA_W    = 8,
  parameter int NUM_REGS  = 16,
  parameter int PHASE_CYC = 4,
  parameter int IDX_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [IDX_W-1:0]  tbl_idx,
  input  logic [DATA_W-1:0] tbl_addr,
  input  logic [DATA_W-1:0] tbl_data,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              ad_o,
  output logic              cs_o,
  output logic              wr_o,
  output logic              rd_o,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [IDX_W-1:0]  err_idx
);

  localparam int                PC_W     = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [PC_W-1:0]   PC_LAST  = PC_W'(PHASE_CYC - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_REGS - 1);

  typedef enum logic [3:0] {
    IDLE,
    A_SET,
    A_STB,
    A_HLD,
    D_SET,
    D_STB,
    D_HLD,
`ifdef RTC_INIT_READBACK_EN
    R_SET,
    R_STB,
    R_HLD,
`endif
    GAP,
    DONE
  } state_t;

  state_t            state_q, state_d;
  logic              en_q, en_prev_q;
  logic [PC_W-1:0]   phase_q, phase_d;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W-1:0] bus_d;
  logic              oe_d, ad_d, cs_d, wr_d, rd_d, busy_d, done_d;

  logic start;
  logic phase_last;
  logic last_entry;

  // Start is an edge of the registered enable, honoured only in IDLE.
  assign start      = en_q & ~en_prev_q;
  assign phase_last = (phase_q == PC_LAST);
  assign last_entry = (tbl_idx == IDX_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in a combinational block gets a default on the
  // first lines so that no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = A_SET;
      DONE: if (!en_q) state_d = IDLE;
      default: begin
        // Any active state: a low enable sample aborts immediately,
        // otherwise advance when the current phase has run its length.
        if (!en_q) begin
          state_d = IDLE;
        end else if (phase_last) begin
          case (state_q)
            A_SET:   state_d = A_STB;
            A_STB:   state_d = A_HLD;
            A_HLD:   state_d = D_SET;
            D_SET:   state_d = D_STB;
            D_STB:   state_d = D_HLD;
`ifdef RTC_INIT_READBACK_EN
            D_HLD:   state_d = R_SET;
            R_SET:   state_d = R_STB;
            R_STB:   state_d = R_HLD;
            R_HLD:   state_d = GAP;
`else
            D_HLD:   state_d = GAP;
`endif
            GAP:     state_d = last_entry ? DONE : A_SET;
            default: state_d = IDLE;
          endcase
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / datapath decode. Outputs are decoded from the next state and
  // registered, so pins change on the same edge as the state.
  // ---------------------------------------------------------------------------
  always_comb begin
    cs_d   = 1'b1;
    wr_d   = 1'b1;
    rd_d   = 1'b1;
    ad_d   = 1'b1;
    oe_d   = 1'b0;
    bus_d  = bus_out;
    busy_d = 1'b1;
    done_d = 1'b0;
    idx_d  = tbl_idx;

    case (state_d)
      IDLE: begin
        busy_d = 1'b0;
        idx_d  = '0;
      end
      DONE: begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
      A_SET, A_STB, A_HLD: begin
        cs_d = 1'b0;
        ad_d = 1'b0;
        oe_d = 1'b1;
        wr_d = (state_d != A_STB);
        // On the GAP->A_SET edge the ROM still shows the previous entry, so
        // bus_out settles to the new address one clock into A_SET; it is
        // stable well before the strobe.
        bus_d = tbl_addr;
      end
      D_SET, D_STB, D_HLD: begin
        cs_d  = 1'b0;
        ad_d  = 1'b1;
        oe_d  = 1'b1;
        wr_d  = (state_d != D_STB);
        bus_d = tbl_data;
      end
`ifdef RTC_INIT_READBACK_EN
      R_SET, R_STB, R_HLD: begin
        cs_d = 1'b0;
        ad_d = 1'b1;
        rd_d = (state_d != R_STB);
      end
`endif
      default: ;  // GAP: bus released, strobes idle, bus_out holds
    endcase

    // Index advances only when leaving GAP for the next entry.
    if (state_q == GAP && state_d == A_SET) begin
      idx_d = tbl_idx + IDX_W'(1);
    end
  end

  // Phase counter restarts on every state change; it idles at 0 outside
  // the active states.
  always_comb begin
    if (state_d != state_q || state_d == IDLE || state_d == DONE) begin
      phase_d = '0;
    end else begin
      phase_d = phase_q + PC_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      en_q      <= 1'b0;
      en_prev_q <= 1'b0;
      phase_q   <= '0;
      tbl_idx   <= '0;
      bus_out   <= '0;
      bus_oe    <= 1'b0;
      ad_o      <= 1'b1;
      cs_o      <= 1'b1;
      wr_o      <= 1'b1;
      rd_o      <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state_q   <= state_d;
      en_q      <= en;
      en_prev_q <= en_q;
      phase_q   <= phase_d;
      tbl_idx   <= idx_d;
      bus_out   <= bus_d;
      bus_oe    <= oe_d;
      ad_o      <= ad_d;
      cs_o      <= cs_d;
      wr_o      <= wr_d;
      rd_o      <= rd_d;
      busy      <= busy_d;
      done      <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Read-back verification
  // ---------------------------------------------------------------------------
`ifdef RTC_INIT_READBACK_EN
  logic rb_sample;
  logic rb_miss;
  logic seq_start;

  // bus_in is sampled on the last clock of the read strobe, unless the
  // sequence is being aborted on that same edge.
  assign rb_sample = (state_q == R_STB) && phase_last && en_q;
  assign rb_miss   = rb_sample && (bus_in != tbl_data);
  assign seq_start = (state_q == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_idx <= '0;
    end else if (seq_start) begin
      err     <= 1'b0;
      err_idx <= '0;
    end else if (rb_miss && !err) begin
      // Only the first mismatch is recorded; err is sticky until restart.
      err     <= 1'b1;
      err_idx <= tbl_idx;
    end
  end
`else
  logic unused_bus_in;
  assign unused_bus_in = ^bus_in;
  assign err           = 1'b0;
  assign err_idx       = '0;
`endif

endmodule

// File: tb/tb_rtc_init_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rtc_init_sequencer
//
// Directed bench for rtc_init_sequencer. A small ROM model feeds the table,
// and bus_in echoes the table data except at indices flagged in bad_mask.
// Expected write strobes are queued when a sequence is launched and popped
// by a negedge monitor as each strobe appears on the bus.
//
// Default build: PHASE_CYC=2, NUM_REGS=3. With RTC_INIT_READBACK_EN defined:
// PHASE_CYC=1, NUM_REGS=4 plus read-back error checks.
// -----------------------------------------------------------------------------
module tb_rtc_init_sequencer;

`ifdef RTC_INIT_READBACK_EN
  localparam int PC     = 1;
  localparam int NR     = 4;
  localparam int STATES = 10;
  localparam bit RB     = 1'b1;
`else
  localparam int PC     = 2;
  localparam int NR     = 3;
  localparam int STATES = 7;
  localparam bit RB     = 1'b0;
`endif
  // Clocks from the first en=1 sample edge to done=1:
  // one clock for edge detection, then NR entries of STATES*PC clocks.
  localparam int DONE_LAT = NR * STATES * PC + 1;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] tbl_idx;
  logic [7:0] tbl_addr;
  logic [7:0] tbl_data;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       bus_oe, ad_o, cs_o, wr_o, rd_o, busy, done, err;
  logic [7:0] err_idx;

  logic [15:0] bad_mask;

  int compared   = 0;
  int mismatched = 0;
  int wr_pulses  = 0;
  int rd_pulses  = 0;

  typedef struct packed {
    logic [7:0] bus;
    logic       ad;
    logic [7:0] idx;
  } strobe_t;

  strobe_t exp_q[$];

  rtc_init_sequencer #(
    .DATA_W   (8),
    .NUM_REGS (NR),
    .PHASE_CYC(PC),
    .IDX_W    (8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .tbl_idx (tbl_idx),
    .tbl_addr(tbl_addr),
    .tbl_data(tbl_data),
    .bus_in  (bus_in),
    .bus_out (bus_out),
    .bus_oe  (bus_oe),
    .ad_o    (ad_o),
    .cs_o    (cs_o),
    .wr_o    (wr_o),
    .rd_o    (rd_o),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .err_idx (err_idx)
  );

  // ROM model
  function automatic logic [7:0] rom_addr(input logic [7:0] i);
    return 8'h40 + (i << 1);
  endfunction

  function automatic logic [7:0] rom_data(input logic [7:0] i);
    return 8'hC3 ^ (i * 8'd29);
  endfunction

  assign tbl_addr = rom_addr(tbl_idx);
  assign tbl_data = rom_data(tbl_idx);
  assign bus_in   = bad_mask[tbl_idx[3:0]] ? ~tbl_data : tbl_data;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ctl"}, {24'h0, cs_o, wr_o, rd_o, ad_o, bus_oe, busy, done, err}, 32'hF0);
    check({tag, "_bus_out"}, {24'h0, bus_out}, 32'h0);
    check({tag, "_tbl_idx"}, {24'h0, tbl_idx}, 32'h0);
    check({tag, "_err_idx"}, {24'h0, err_idx}, 32'h0);
  endtask

  // Expected err/err_idx for the indices visited so far: first flagged index.
  task automatic check_err(input string tag, input logic [15:0] mask, input int upto);
    logic       e_err = 1'b0;
    logic [7:0] e_idx = 8'h0;
    if (RB) begin
      for (int i = upto - 1; i >= 0; i--) begin
        if (mask[i]) begin
          e_err = 1'b1;
          e_idx = 8'(i);
        end
      end
    end
    check({tag, "_err"}, {31'h0, err}, {31'h0, e_err});
    check({tag, "_err_idx"}, {24'h0, err_idx}, {24'h0, e_idx});
  endtask

  task automatic push_entry(input int i, input bit with_data);
    strobe_t s;
    s.bus = rom_addr(8'(i));
    s.ad  = 1'b0;
    s.idx = 8'(i);
    exp_q.push_back(s);
    if (with_data) begin
      s.bus = rom_data(8'(i));
      s.ad  = 1'b1;
      exp_q.push_back(s);
    end
  endtask

  task automatic launch_full();
    wr_pulses = 0;
    rd_pulses = 0;
    for (int i = 0; i < NR; i++) push_entry(i, 1'b1);
  endtask

  // Counts edges (elapsed already spent since en rose) until done is seen.
  task automatic wait_done(input int elapsed, input string tag);
    int n = elapsed;
    do begin
      step();
      n++;
    end while (!done && n < DONE_LAT + 40);
    check(tag, n - 1, DONE_LAT);
  endtask

  task automatic check_run(input string tag);
    check({tag, "_wr_pulses"}, wr_pulses, 2 * NR);
    check({tag, "_rd_pulses"}, rd_pulses, RB ? NR : 0);
    check({tag, "_queue_left"}, exp_q.size(), 0);
    check({tag, "_busy_done"}, {30'h0, busy, done}, 32'h1);
    check({tag, "_last_idx"}, {24'h0, tbl_idx}, NR - 1);
  endtask

  // Strobe / gap monitor, sampled on the falling edge.
  initial begin
    int      wr_run  = 0;
    int      cs_run  = 0;
    logic    rd_prev = 1'b1;
    strobe_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_run  = 0;
        cs_run  = 0;
        rd_prev = 1'b1;
      end else begin
        if (!wr_o) begin
          if (wr_run == 0) begin
            wr_pulses++;
            if (exp_q.size() == 0) begin
              check("strobe_expected", 0, 1);
            end else begin
              e = exp_q.pop_front();
              check("strobe_bus_out", {24'h0, bus_out}, {24'h0, e.bus});
              check("strobe_ad_o", {31'h0, ad_o}, {31'h0, e.ad});
              check("strobe_idx", {24'h0, tbl_idx}, {24'h0, e.idx});
              check("strobe_cs_oe", {30'h0, cs_o, bus_oe}, 32'h1);
            end
          end
          wr_run++;
        end else begin
          if (wr_run != 0 && busy) check("wr_width", wr_run, PC);
          wr_run = 0;
        end

        if (!busy) begin
          cs_run = 0;
        end else if (cs_o) begin
          cs_run++;
        end else begin
          if (cs_run != 0) check("cs_gap", cs_run, PC);
          cs_run = 0;
        end

        if (!rd_o && rd_prev) rd_pulses++;
        rd_prev = rd_o;
      end
    end
  end

  initial begin
    int found;

    rst_n    = 1'b1;
    en       = 1'b0;
    bad_mask = 16'h0;
    #1 rst_n = 1'b0;
    #2;
    check_reset("reset_init");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    step();
    check_reset("idle_after_reset");

    // Full sequence from a clean enable edge (idx 2 bad for read-back).
    bad_mask = 16'h0004;
    launch_full();
    en = 1'b1;
    wait_done(0, "run1_done_latency");
    check_run("run1");
    check_err("run1", bad_mask, NR);

    // done holds while en stays high.
    repeat (5) step();
    check("done_hold", {31'h0, done}, 32'h1);

    // One-clock low pulse on en: done clears, then a full rerun.
    bad_mask = 16'h0;
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    check("pulse_done_cleared", {30'h0, busy, done}, 32'h0);
    launch_full();
    wait_done(1, "run2_done_latency");
    check_run("run2");
    check_err("run2", bad_mask, NR);

    // Abort during the address strobe of entry 1.
    en = 1'b0;
    step();
    step();
    bad_mask  = 16'h0001;
    wr_pulses = 0;
    rd_pulses = 0;
    push_entry(0, 1'b1);
    push_entry(1, 1'b0);
    en    = 1'b1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (tbl_idx == 8'd1 && !wr_o) begin
        found = 1;
        break;
      end
    end
    check("abort_reach_entry1", found, 1);
    en = 1'b0;
    step();
    step();
    check("abort_ctl", {27'h0, cs_o, wr_o, bus_oe, busy, done}, 32'h18);
    check("abort_tbl_idx", {24'h0, tbl_idx}, 32'h0);
    check("abort_wr_pulses", wr_pulses, 3);
    check("abort_rd_pulses", rd_pulses, RB ? 1 : 0);
    check("abort_queue_left", exp_q.size(), 0);
    check_err("abort_kept", bad_mask, 1);

    // Restart after abort: begins at idx 0, new start clears err.
    bad_mask = 16'h000A;
    launch_full();
    en = 1'b1;
    step();
    step();
    step();
    check("restart_err_cleared", {31'h0, err}, 32'h0);
    wait_done(3, "run3_done_latency");
    check_run("run3");
    check_err("run3", bad_mask, NR);

    // Asynchronous reset in the middle of the data strobe.
    en = 1'b0;
    step();
    step();
    wr_pulses = 0;
    push_entry(0, 1'b1);
    en    = 1'b1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (!wr_o && ad_o) begin
        found = 1;
        break;
      end
    end
    check("reset_reach_dstb", found, 1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset("reset_mid_seq");
    check("reset_queue_left", exp_q.size(), 0);
    en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check_reset("reset_release");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rtc_init_sequencer.md
Name: rtc_init_sequencer

Overview:
- Parametrised successor to the RTC power-up initialisation block.
- On an enable rising edge it walks a register table of NUM_REGS address/data pairs. Each pair is written to the RTC over a multiplexed AD bus with active-low CS/WR/RD and an AD select line. Each bus phase lasts a programmable number of clocks.
- It sits between the top-level control FSM and the RTC pad drivers. The table ROM is external and looked up combinationally through tbl_idx.
- It adds configurable timing, abort, a table interface and optional read-back verification.

Parameters:
- DATA_W, 8: AD bus and table data width.
- NUM_REGS, 16: number of table entries to write; must be 1..256.
- PHASE_CYC, 4: clocks per bus phase (setup, strobe, hold, gap); must be ≥1.
- IDX_W, 8: width of tbl_idx; must be ≥ clog2(NUM_REGS).

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  asynchronous, active-low reset.
- en  in  1  level enable; a rising edge starts the sequence, low aborts or clears.
- tbl_idx  out  IDX_W  current table index.
- tbl_addr  in  DATA_W  RTC register address for tbl_idx.
- tbl_data  in  DATA_W  value for tbl_idx.
- bus_in  in  DATA_W  AD bus read data.
- bus_out  out  DATA_W  AD bus drive value.
- bus_oe  out  1  AD bus output enable.
- ad_o  out  1  0 = address cycle, 1 = data cycle.
- cs_o  out  1  chip select, active low.
- wr_o  out  1  write strobe, active low.
- rd_o  out  1  read strobe, active low.
- busy  out  1  sequence in progress.
- done  out  1  all entries written (equivalent of ban_fin).
- err  out  1  sticky read-back mismatch.
- err_idx  out  IDX_W  index of the first mismatch.

Behaviour:
- Reset values: cs_o=wr_o=rd_o=ad_o=1, bus_out=0, bus_oe=0, busy=0, done=0, err=0, err_idx=0, tbl_idx=0, state IDLE. All outputs are registered.
- en is registered once. Start is detected when en is sampled 1 and the previous sample was 0, in IDLE only. The next state is A_SET, busy=1, tbl_idx=0.
- Every phase lasts exactly PHASE_CYC clocks, timed by a phase counter that clears on each state change.
- State sequence per entry: A_SET → A_STB → A_HLD → D_SET → D_STB → D_HLD → [R_SET → R_STB → R_HLD] → GAP.
- Address phases (A_*): cs_o=0, ad_o=0, bus_oe=1, bus_out=tbl_addr. wr_o=0 only in A_STB.
- Data phases (D_*): cs_o=0, ad_o=1, bus_oe=1, bus_out=tbl_data. wr_o=0 only in D_STB.
- GAP: cs_o=1, wr_o=1, rd_o=1, ad_o=1, bus_oe=0. bus_out holds its last value.
- Leaving GAP:
  - If tbl_idx == NUM_REGS-1, go to DONE: busy=0, done=1.
  - Otherwise increment tbl_idx and go to A_SET.
- Entry length is 7·PHASE_CYC clocks; with read-back it is 10·PHASE_CYC.
- DONE holds done=1 while en=1. When en is sampled 0, go to IDLE with done=0. A restart needs a new rising edge.
- Abort: en sampled 0 in any active state forces IDLE on the next clock.
  - cs_o, wr_o and rd_o go to 1 and bus_oe to 0.
  - busy=0, done stays 0, tbl_idx=0.
  - err is kept.
- A new start clears err and err_idx.
- tbl_addr and tbl_data must be stable from A_SET through GAP. The block reads them combinationally every cycle and does not latch them.
- NUM_REGS=1: a single entry, then DONE.

Optional Feature:
- Macro: RTC_INIT_READBACK_EN.
- Defined: after D_HLD the block runs the read-back phases.
  - R_SET: cs_o=0, ad_o=1, bus_oe=0.
  - R_STB: rd_o=0. bus_in is sampled on the last R_STB clock and compared with tbl_data.
  - R_HLD: then GAP.
  - On a mismatch with err=0: set err=1 and err_idx=tbl_idx. Later mismatches leave err_idx unchanged.
- Undefined: the R_* states are absent, rd_o is constant 1, err=0 and err_idx=0. bus_in is unused but the port remains.

Test Plan:
- Reset mid-sequence (Rst low during D_STB) → all outputs return to their reset values asynchronously, with no wait for a clock edge.
- PHASE_CYC=2, NUM_REGS=3, macro off, en rises → done=1 exactly 43 clocks after the first en=1 sample. Check:
  - 6 wr_o low pulses, each 2 clocks wide.
  - bus_out equals tbl_addr/tbl_data, ad_o 0/1 respectively, during each strobe.
  - cs_o high for 2 clocks between entries.
- Abort: en falls during entry 1 A_STB → IDLE next clock with cs_o=1, wr_o=1, done=0, tbl_idx=0. A subsequent en rise restarts from idx 0.
- en held high after done, then pulsed low for 1 clock and high again → done clears, then the sequence reruns fully.
- Macro on, PHASE_CYC=1, NUM_REGS=4, bus_in mirrors tbl_data except idx 2 (returns ~tbl_data) → err=1, err_idx=2, done after 41 clocks, one rd_o pulse per entry.
- Macro on, mismatches at idx 1 and idx 3 → err_idx=1. A new start clears err.
